// File: rtl/posit16_0_unpack_seq.sv
// rtl/posit16_0_unpack_seq.sv - serial posit<16,0> decoder into sign, regime scale and fraction
// Regime bits are consumed one per clock from a shift register holding the magnitude.
module posit16_0_unpack_seq #(
  parameter int N  = 16,
  parameter int FW = N - 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_nar,
  output logic [4:0]    out_scale,
  output logic [FW:0]   out_frac
);

  localparam int RW = $clog2(N);
  localparam int SW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [N-2:0]  sr;
  logic [RW-1:0] run;
  logic          first;

  logic          accept;
  logic          is_zero;
  logic          is_nar;
  logic [N-2:0]  mag;
  logic          match;
  logic          last;
  logic          scan_end;
  logic [RW-1:0] run_fin;
  logic [SW-1:0] scale_w;
  logic [FW-1:0] frac_w;

  assign accept  = in_valid && in_ready;
  assign is_zero = (in_posit == '0);
  assign is_nar  = (in_posit == {1'b1, {(N-1){1'b0}}});
  // Low N-1 bits of the two's complement; the sign bit of the magnitude is always 0.
  assign mag     = in_posit[N-1] ? (~in_posit[N-2:0] + 1'b1) : in_posit[N-2:0];

  assign match    = (sr[N-2] == first);
  assign last     = match && (run == RW'(N - 2));
  assign scan_end = (state == SCAN) && (!match || last);
  assign run_fin  = match ? (run + 1'b1) : run;
  assign scale_w  = first ? (SW'(run_fin) - SW'(1)) : (SW'(0) - SW'(run_fin));
  // After this cycle's shift the bits following the terminator sit at sr[N-3:1].
  assign frac_w   = sr[N-3:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = (is_zero || is_nar) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (!match || last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr        <= '0;
      run       <= '0;
      first     <= 1'b0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
      out_scale <= '0;
      out_frac  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_sign  <= in_posit[N-1];
            out_zero  <= is_zero;
            out_nar   <= is_nar;
            out_scale <= '0;
            out_frac  <= '0;
            sr        <= mag;
            run       <= '0;
            first     <= mag[N-2];
          end
        end
        SCAN: begin
          sr <= {sr[N-3:0], 1'b0};
          if (match) begin
            run <= run + 1'b1;
          end
          if (scan_end) begin
            out_scale <= scale_w;
            out_frac  <= {1'b1, frac_w};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit16_0_unpack_seq.sv
// tb/tb_posit16_0_unpack_seq.sv - directed and randomized bench for posit16_0_unpack_seq
// Expected fields and latency come from a value-level posit decoding model.
module tb_posit16_0_unpack_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_posit;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic        out_zero;
  logic        out_nar;
  logic [4:0]  out_scale;
  logic [13:0] out_frac;

  int checks = 0;
  int failures = 0;

  posit16_0_unpack_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .out_scale (out_scale),
    .out_frac  (out_frac)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] w, output logic s, output logic z,
                                output logic na, output int k, output int frac, output int lat);
    int mag, first, r, rem;
    s = w[15];
    z = (w == 16'h0000);
    na = (w == 16'h8000);
    k = 0;
    frac = 0;
    lat = 1;
    if (z || na) return;
    mag = s ? (65536 - int'(w)) : int'(w);
    first = (mag >> 14) & 1;
    r = 0;
    while (r < 15 && ((mag >> (14 - r)) & 1) == first) r++;
    k = (first == 1) ? r - 1 : -r;
    if (r < 15) begin
      lat = r + 2;
      rem = 14 - r;
      frac = (mag & ((1 << rem) - 1)) << (13 - rem);
    end else begin
      lat = 16;
    end
    frac = frac | 'h2000;
  endfunction

  task automatic check_fields(input string tag, input logic es, input logic ez, input logic en,
                              input int ek, input int ef);
    check({tag, "_sign"}, 32'(out_sign), 32'(es));
    check({tag, "_zero"}, 32'(out_zero), 32'(ez));
    check({tag, "_nar"}, 32'(out_nar), 32'(en));
    check({tag, "_scale"}, {{27{out_scale[4]}}, out_scale}, 32'(ek));
    check({tag, "_frac"}, 32'(out_frac), 32'(ef));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_word(input logic [15:0] w, input logic es, input logic ez, input logic en,
                          input int ek, input int ef, input int el, input int hold);
    int n;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_posit = w;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_posit = 16'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom);
      in_posit = 16'($urandom);
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    check($sformatf("latency_%04h", w), 32'(n), 32'(el));
    if (!out_valid) begin
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    check("busy_in_ready", 32'(in_ready), 32'd0);
    check_fields($sformatf("w%04h", w), es, ez, en, ek, ef);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_posit = 16'($urandom);
      @(posedge clock);
      @(negedge clock);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check_fields("hold", es, ez, en, ek, ef);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic ms, mz, mn;
  int mk, mf, ml;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_posit = 16'h0000;
    out_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_fields("rst", 1'b0, 1'b0, 1'b0, 0, 0);
    reset = 1'b0;

    run_word(16'h7E00, 1'b0, 1'b0, 1'b0, 5, 'h2000, 8, 0);
    run_word(16'h7F08, 1'b0, 1'b0, 1'b0, 6, 'h2200, 9, 0);
    run_word(16'h7F12, 1'b0, 1'b0, 1'b0, 6, 'h2480, 9, 0);
    run_word(16'hC000, 1'b1, 1'b0, 1'b0, 0, 'h2000, 3, 0);
    run_word(16'h7FFF, 1'b0, 1'b0, 1'b0, 14, 'h2000, 16, 0);
    run_word(16'h0001, 1'b0, 1'b0, 1'b0, -14, 'h2000, 16, 0);
    run_word(16'h8001, 1'b1, 1'b0, 1'b0, 14, 'h2000, 16, 0);
    run_word(16'h0000, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0);
    run_word(16'h8000, 1'b1, 1'b0, 1'b1, 0, 0, 1, 0);
    run_word(16'h7E00, 1'b0, 1'b0, 1'b0, 5, 'h2000, 8, 5);

    // Abandon a scan with reset.
    in_posit = 16'h0001;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("scan_no_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("after_rst_no_valid", 32'(out_valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    run_word(16'h7E00, 1'b0, 1'b0, 1'b0, 5, 'h2000, 8, 0);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (i % 16 == 0) w = 16'h8000;
      if (i % 16 == 8) w = 16'h0000;
      model(w, ms, mz, mn, mk, mf, ml);
      run_word(w, ms, mz, mn, mk, mf, ml, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
